// File: rtl/line_draw_pkg.sv
// Shared definitions for the line drawing engine: default geometry,
// FSM state encodings and the internal coordinate width derivation.
package line_draw_pkg;

  // Default screen geometry: 320x240 pixels with 3-bit colour.
  localparam int DEF_XW = 9;
  localparam int DEF_YW = 8;
  localparam int DEF_CW = 3;

  // FSM state encodings.
  localparam logic [1:0] IDLE_ENC  = 2'd0;
  localparam logic [1:0] SETUP_ENC = 2'd1;
  localparam logic [1:0] DRAW_ENC  = 2'd2;
  localparam logic [1:0] DONE_ENC  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = IDLE_ENC,
    SETUP = SETUP_ENC,
    DRAW  = DRAW_ENC,
    DONE  = DONE_ENC
  } state_t;

  // Internal coordinate width: wide enough for either axis to act as major.
  function automatic int coord_width(input int xw, input int yw);
    return (xw > yw) ? xw : yw;
  endfunction

endpackage

// File: rtl/line_octant_norm.sv
// Combinational octant normalisation: maps arbitrary endpoints onto a
// major axis that always steps +1, plus the minor-axis delta and direction.
module line_octant_norm
  import line_draw_pkg::*;
#(
  parameter int XW = DEF_XW,
  parameter int YW = DEF_YW,
  parameter int W  = coord_width(XW, YW)
) (
  input  logic [XW-1:0] x0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y0,
  input  logic [YW-1:0] y1,
  output logic          steep,
  output logic [W-1:0]  a0,
  output logic [W-1:0]  a1,
  output logic [W-1:0]  b0,
  output logic [W-1:0]  da,
  output logic [W-1:0]  db,
  output logic          bstep   // 1: minor axis steps +1, 0: steps -1
);

  logic [W-1:0] xs0, xs1, ys0, ys1;
  logic [W-1:0] adx, ady;
  logic [W-1:0] pa0, pa1, pb0, pb1;
  logic [W-1:0] b1_s;

  // Pick the major axis, order endpoints by ascending major coordinate.
  // NOTE: every output of this always_comb is assigned on every path,
  // otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    xs0 = W'(x0);
    xs1 = W'(x1);
    ys0 = W'(y0);
    ys1 = W'(y1);

    adx   = (xs1 >= xs0) ? (xs1 - xs0) : (xs0 - xs1);
    ady   = (ys1 >= ys0) ? (ys1 - ys0) : (ys0 - ys1);
    steep = (ady > adx);

    pa0 = steep ? ys0 : xs0;
    pa1 = steep ? ys1 : xs1;
    pb0 = steep ? xs0 : ys0;
    pb1 = steep ? xs1 : ys1;

    if (pa0 > pa1) begin
      a0   = pa1;
      a1   = pa0;
      b0   = pb1;
      b1_s = pb0;
    end else begin
      a0   = pa0;
      a1   = pa1;
      b0   = pb0;
      b1_s = pb1;
    end

    da    = a1 - a0;
    bstep = (b0 <= b1_s);
    db    = bstep ? (b1_s - b0) : (b0 - b1_s);
  end

endmodule

// File: rtl/line_draw_engine.sv
// Bresenham line engine: latches a line command, normalises it to a single
// octant, then streams one pixel per accepted transfer over valid/ready.
module line_draw_engine
  import line_draw_pkg::*;
#(
  parameter int XW = DEF_XW,
  parameter int YW = DEF_YW,
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic          abort,
  input  logic [XW-1:0] x0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y0,
  input  logic [YW-1:0] y1,
  input  logic [CW-1:0] color,
  output logic          busy,
  output logic          done,
  output logic          plot_valid,
  input  logic          plot_ready,
  output logic [XW-1:0] plot_x,
  output logic [YW-1:0] plot_y,
  output logic [CW-1:0] plot_color
);

  localparam int W  = coord_width(XW, YW);
  localparam int EW = W + 2;   // signed error term with headroom

  state_t state_q, state_d;

  // Command latched in IDLE; the normaliser works from these during SETUP.
  logic [XW-1:0] ex0_q, ex1_q;
  logic [YW-1:0] ey0_q, ey1_q;
  logic [CW-1:0] color_q;

  // Normalised line, registered at the end of SETUP.
  logic                 n_steep, n_bstep;
  logic [W-1:0]         n_a0, n_a1, n_b0, n_da, n_db;
  logic                 steep_q, bstep_q;
  logic [W-1:0]         a_q, a1_q, b_q, da_q, db_q;
  logic signed [EW-1:0] err_q, err_sum;

  logic xfer;
  logic last_pixel;

  line_octant_norm #(
    .XW (XW),
    .YW (YW),
    .W  (W)
  ) u_norm (
    .x0    (ex0_q),
    .x1    (ex1_q),
    .y0    (ey0_q),
    .y1    (ey1_q),
    .steep (n_steep),
    .a0    (n_a0),
    .a1    (n_a1),
    .b0    (n_b0),
    .da    (n_da),
    .db    (n_db),
    .bstep (n_bstep)
  );

  assign plot_valid = (state_q == DRAW);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign plot_x     = steep_q ? b_q[XW-1:0] : a_q[XW-1:0];
  assign plot_y     = steep_q ? a_q[YW-1:0] : b_q[YW-1:0];
  assign plot_color = color_q;

  assign xfer       = plot_valid && plot_ready;
  assign last_pixel = (a_q == a1_q);
  assign err_sum    = err_q + $signed({2'b00, db_q});

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs at the same edge regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state decode; abort wins over start and over the last transfer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start && !abort) state_d = SETUP;
      SETUP:   state_d = abort ? IDLE : DRAW;
      DRAW: begin
        if (abort)                   state_d = IDLE;
        else if (xfer && last_pixel) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command latch, octant setup and the per-transfer Bresenham step.
  // NOTE: every datapath register is cleared by reset so the outputs read
  // zero immediately, not only once the FSM leaves IDLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ex0_q   <= '0;
      ex1_q   <= '0;
      ey0_q   <= '0;
      ey1_q   <= '0;
      color_q <= '0;
      steep_q <= 1'b0;
      bstep_q <= 1'b0;
      a_q     <= '0;
      a1_q    <= '0;
      b_q     <= '0;
      da_q    <= '0;
      db_q    <= '0;
      err_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && !abort) begin
            ex0_q   <= x0;
            ex1_q   <= x1;
            ey0_q   <= y0;
            ey1_q   <= y1;
            color_q <= color;
          end
        end
        SETUP: begin
          steep_q <= n_steep;
          bstep_q <= n_bstep;
          a_q     <= n_a0;
          a1_q    <= n_a1;
          b_q     <= n_b0;
          da_q    <= n_da;
          db_q    <= n_db;
          err_q   <= -$signed({2'b00, n_da >> 1});
        end
        DRAW: begin
          // A stalled pixel leaves every register untouched.
          if (xfer && !last_pixel) begin
            if (!err_sum[EW-1]) begin
              b_q   <= bstep_q ? (b_q + W'(1)) : (b_q - W'(1));
              err_q <= err_sum - $signed({2'b00, da_q});
            end else begin
              err_q <= err_sum;
            end
            a_q <= a_q + W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_line_draw_engine.sv
// Self-checking bench for line_draw_engine: directed lines from the test
// plan plus random lines, compared against a Bresenham pixel-list model.
module tb_line_draw_engine;

  localparam int XW = 9;
  localparam int YW = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          plot_ready = 1'b1;
  logic [XW-1:0] x0 = '0, x1 = '0;
  logic [YW-1:0] y0 = '0, y1 = '0;
  logic [CW-1:0] color = '0;
  logic          busy, done, plot_valid;
  logic [XW-1:0] plot_x;
  logic [YW-1:0] plot_y;
  logic [CW-1:0] plot_color;

  int vectors     = 0;
  int miscompares = 0;
  int exp_x[$];
  int exp_y[$];

  always #5 clk = ~clk;

  line_draw_engine #(.XW(XW), .YW(YW), .CW(CW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .abort      (abort),
    .x0         (x0),
    .x1         (x1),
    .y0         (y0),
    .y1         (y1),
    .color      (color),
    .busy       (busy),
    .done       (done),
    .plot_valid (plot_valid),
    .plot_ready (plot_ready),
    .plot_x     (plot_x),
    .plot_y     (plot_y),
    .plot_color (plot_color)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    vectors++;
    assert (obs === expd)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expd);
    end
  endtask

  // Reference: the full pixel list of a line, in ascending major-axis order.
  function automatic void build_expected(input int xa, input int ya, input int xb, input int yb);
    int dx, dy, a0, a1, b0, b1, t, da, db, step, err, e, b;
    bit steep;
    exp_x.delete();
    exp_y.delete();
    dx    = (xb > xa) ? xb - xa : xa - xb;
    dy    = (yb > ya) ? yb - ya : ya - yb;
    steep = dy > dx;
    a0 = steep ? ya : xa;  a1 = steep ? yb : xb;
    b0 = steep ? xa : ya;  b1 = steep ? xb : yb;
    if (a0 > a1) begin
      t = a0; a0 = a1; a1 = t;
      t = b0; b0 = b1; b1 = t;
    end
    da   = a1 - a0;
    db   = (b1 > b0) ? b1 - b0 : b0 - b1;
    step = (b0 <= b1) ? 1 : -1;
    err  = -(da / 2);
    b    = b0;
    for (int a = a0; a <= a1; a++) begin
      exp_x.push_back(steep ? b : a);
      exp_y.push_back(steep ? a : b);
      e = err + db;
      if (e >= 0) begin
        b   = b + step;
        err = e - da;
      end else begin
        err = e;
      end
    end
  endfunction

  // Draw one line; optionally random ready, abort on pixel abort_at, or a
  // start pulse (with scrambled endpoints) in the middle of DRAW.
  task automatic run_line(input int xa, input int ya, input int xb, input int yb, input int c,
                          input bit rnd, input int abort_at, input bit poke);
    int n, idx, cyc, last_xfer;
    bit fin, aborted;
    build_expected(xa, ya, xb, yb);
    n = exp_x.size();
    idx = 0; cyc = 1; last_xfer = -1; fin = 0; aborted = 0;
    x0 = XW'(xa); y0 = YW'(ya); x1 = XW'(xb); y1 = YW'(yb); color = CW'(c);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("setup_busy", busy, 1);
    check("setup_valid", plot_valid, 0);
    while (!fin && cyc < 4000) begin
      plot_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (done) begin
        fin = 1;
        check("done_after_last", cyc, last_xfer + 1);
        check("pixel_count", idx, n);
        if (!rnd) check("done_cycle", cyc, n + 2);
      end else if (plot_valid) begin
        if (idx < n) begin
          check("pix_x", plot_x, exp_x[idx]);
          check("pix_y", plot_y, exp_y[idx]);
          check("pix_color", plot_color, c);
        end else begin
          check("pixel_overrun", idx, n - 1);
        end
        if (plot_ready) begin
          last_xfer = cyc;
          if (idx == abort_at) abort = 1'b1;
          idx++;
        end
        if (poke && idx == 2) begin
          poke  = 0;
          start = 1'b1;
          x0 = XW'($urandom_range(0, 319));
          y1 = YW'($urandom_range(0, 239));
          color = ~color;
        end
      end
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (abort) begin
        abort = 1'b0;
        aborted = 1;
        fin = 1;
        check("abort_busy", busy, 0);
        check("abort_valid", plot_valid, 0);
        check("abort_done", done, 0);
        repeat (3) begin
          @(posedge clk); #1;
          check("abort_no_done", done, 0);
        end
      end
    end
    check("line_finished", fin, 1);
    if (fin && !aborted) begin
      @(posedge clk); #1;
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      @(posedge clk); #1;
      check("start_dropped", busy, 0);
    end
    plot_ready = 1'b1;
  endtask

  initial begin
    // Reset state.
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", plot_valid, 0);
    check("rst_x", plot_x, 0);
    check("rst_y", plot_y, 0);
    check("rst_color", plot_color, 0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Directed lines from the test plan.
    run_line(0, 0, 4, 2, 3, 0, -1, 0);
    run_line(4, 2, 0, 0, 6, 0, -1, 0);
    run_line(2, 1, 0, 5, 1, 0, -1, 0);
    run_line(319, 239, 319, 239, 7, 0, -1, 0);
    run_line(0, 7, 319, 7, 2, 0, -1, 0);
    run_line(10, 10, 30, 17, 5, 1, -1, 0);
    run_line(0, 0, 10, 3, 4, 0, 2, 0);
    run_line(5, 200, 60, 20, 3, 0, -1, 1);

    // abort takes priority over start in IDLE.
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("abort_prio_busy", busy, 0);
    @(posedge clk); #1;
    check("abort_prio_busy2", busy, 0);

    // Random lines with random back-pressure.
    for (int i = 0; i < 20; i++) begin
      run_line($urandom_range(0, 319), $urandom_range(0, 239),
               $urandom_range(0, 319), $urandom_range(0, 239),
               $urandom_range(0, 7), 1'($urandom_range(0, 1)), -1, 0);
    end

    // Asynchronous reset in the middle of DRAW.
    x0 = 9'd10; y0 = 8'd10; x1 = 9'd30; y1 = 8'd17; color = 3'd5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("pre_rst_valid", plot_valid, 1);
    resetn = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_valid", plot_valid, 0);
    check("mid_rst_x", plot_x, 0);
    check("mid_rst_y", plot_y, 0);
    check("mid_rst_color", plot_color, 0);
    #3;
    resetn = 1'b1;
    @(posedge clk); #1;

    // Recovery after reset.
    run_line(3, 3, 8, 0, 6, 0, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/line_draw_engine.md
# line_draw_engine

Parametrised Bresenham line engine that rasterises one line between two arbitrary endpoints and emits pixels to the frame-buffer writer (vga_adapter path) over a valid/ready stream. It handles all eight octants and both endpoint orders. It adds configurable coordinate and colour widths, a pixel back-pressure handshake, an abort input and a completion pulse. It sits between the line-command source (switch/FSM front end) and the VGA adapter, and replaces the hand-sequenced datapath-plus-control pair with a self-contained unit.

## Interface
- XW, 9: x coordinate width (320-wide screen)
- YW, 8: y coordinate width
- CW, 3: colour width
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- start  in  1  request to draw; sampled only in IDLE
- abort  in  1  synchronous cancel of the current line
- x0, x1  in  XW  endpoint x coordinates, unsigned
- y0, y1  in  YW  endpoint y coordinates, unsigned
- color  in  CW  pixel colour, latched with the endpoints
- busy  out  1  high in SETUP, DRAW and DONE
- done  out  1  one-cycle pulse after the last pixel transfers
- plot_valid  out  1  pixel available
- plot_ready  in  1  consumer accepts the pixel
- plot_x  out  XW; plot_y  out  YW; plot_color  out  CW  pixel data

## Operation
- Internal width: W = max(XW,YW). Coordinates are zero-extended to W. The error register is signed W+2 bits. Step is ±1.
- FSM states and transitions:
  - IDLE: if start && !abort, latch x0/y0/x1/y1/color, go to SETUP.
  - SETUP: one cycle, then DRAW.
  - DRAW: stays until the last transfer, then DONE.
  - DONE: one cycle, done=1, then IDLE.
- SETUP computes the following into registers:
  - steep = |y1−y0| > |x1−x0|.
  - Major/minor coordinates: a=(steep?y:x), b=(steep?x:y).
  - If a0>a1, swap the endpoints.
  - da=a1−a0; db=|b1−b0|; bstep=(b0≤b1)?+1:−1; err=−(da>>1); a=a0; b=b0.
- DRAW presents plot_x=(steep?b:a) and plot_y=(steep?a:b), truncated to XW/YW, with plot_valid=1.
- On each transfer (plot_valid && plot_ready):
  - If a==a1, go to DONE.
  - Otherwise, with e=err+db: if e≥0, then b←b+bstep and err←e−da; else err←e. Then a←a+1.
- Pixel count per line is da+1. A degenerate line (identical endpoints) emits exactly one pixel. Pixels are emitted in ascending major-axis order regardless of input order.
- Inputs x0..color are ignored outside IDLE.
- start asserted in SETUP, DRAW or DONE is dropped, not queued.
- abort in SETUP or DRAW goes to IDLE next cycle with no done pulse. A transfer coincident with abort counts as delivered. abort has priority over start in IDLE.
- Reset values: busy=0, done=0, plot_valid=0, plot_x=0, plot_y=0, plot_color=0. FSM=IDLE. All internal registers 0.
- resetn low mid-line clears everything immediately (asynchronous). The partial line is lost.

## Timing
- start sampled at edge k: SETUP in cycle k+1; first plot_valid in cycle k+2.
- With plot_ready held high, one pixel per cycle: DRAW occupies cycles k+2 .. k+2+da, DONE/done in cycle k+3+da, IDLE in cycle k+4+da.
- The earliest next start is sampled at the edge ending cycle k+4+da (back-to-back gap of 2 cycles).
- While plot_valid && !plot_ready, plot_x/plot_y/plot_color and all engine state hold stable.
- plot_valid never drops without a transfer, except on abort or reset.
- All outputs are registered or decoded from registered state only. There is no combinational path from plot_ready to plot_valid or data.

## Structure
- Shared package line_draw_pkg holds the FSM state encodings (IDLE, SETUP, DRAW, DONE as localparams), the default XW/YW/CW, and the W derivation.
- One sub-module, line_octant_norm, is combinational. Inputs: endpoints. Outputs: steep, a0, a1, b0, da, db, bstep. It is registered by the engine in SETUP.
- The step/error datapath and the FSM stay in line_draw_engine.

## Test plan
- (0,0)->(4,2), ready=1 -> pixels (0,0),(1,1),(2,1),(3,2),(4,2); done at cycle k+7; busy low at k+8.
- (4,2)->(0,0) -> the identical five pixels in the same ascending-x order.
- Steep (2,1)->(0,5) -> (2,1),(1,2),(1,3),(0,4),(0,5).
- (319,239)->(319,239) -> one pixel (319,239), then done. Horizontal (0,7)->(319,7) -> 320 pixels, all y=7.
- Random plot_ready (~50%) on (10,10)->(30,17) -> same 21-pixel sequence as with ready=1; data stable during stalls; no pixel dropped or duplicated.
- Interruptions:
  - abort on the 3rd pixel -> IDLE next cycle, no done.
  - resetn low mid-DRAW -> all outputs 0 immediately.
  - start during DRAW -> ignored.
